mpi_tx_sched: RTL and testbench

- Credit-based transmit scheduler in front of the MPI send bridge (the DPI snd path). It shares one outbound MPI channel between NUM_REQ local requesters.
- Requesters present valid/data/dest. The block picks a winner round-robin, takes the payload with a yumi, holds it on the bridge port until accepted, and only issues when a send credit is available.
- Credits are returned by the receive side over the credit-return pulse.

---
 rtl/mpi_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/mpi_tx_sched.sv | 75 +++++++
 tb/tb_mpi_tx_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpi_pkg.sv
// mpi_pkg: shared message type, FSM state encoding and default widths for the MPI transmit path.
package mpi_pkg;
   localparam int MPI_DATA_W = 64;
   localparam int MPI_DEST_W = 32;
   typedef struct packed {
      logic [MPI_DATA_W-1:0] data;
      logic [MPI_DEST_W-1:0] dest;
   } mpi_msg_t;
   typedef enum logic {IDLE, SEND} tx_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping.
module rr_arbiter import mpi_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);
   logic             found;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] k;
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      k     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(i);
         k   = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end
endmodule

// File: rtl/mpi_tx_sched.sv
// mpi_tx_sched: credit-gated round-robin scheduler feeding the MPI send bridge.
// Define MPI_TX_SCHED_STATS_EN to add the tx_count and stall_cycles counters.
module mpi_tx_sched import mpi_pkg::*; #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = MPI_DATA_W,
   parameter int DEST_W   = MPI_DEST_W,
   parameter int MAX_CRED = 4,
   parameter int CRED_W   = $clog2(MAX_CRED + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ*DEST_W-1:0] req_dest,
   output logic [NUM_REQ-1:0]        req_yumi,
   output logic                  snd_valid,
   output logic [DATA_W-1:0]     snd_data,
   output logic [DEST_W-1:0]     snd_dest,
   input  logic                  snd_ready,
   input  logic                  cred_ret,
   output logic [CRED_W-1:0]     cred_cnt,
   output logic                  cred_err
`ifdef MPI_TX_SCHED_STATS_EN
   ,
   output logic [31:0]           tx_count,
   output logic [31:0]           stall_cycles
`endif
);
   localparam int IDX_W = $clog2(NUM_REQ);
   tx_state_e        state;
   logic [IDX_W-1:0] ptr, idx;
   logic [NUM_REQ-1:0] gnt;
   logic grant, full, give;
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(req_valid), .ptr(ptr), .gnt(gnt), .idx(idx));
   assign grant    = state == IDLE && |req_valid && cred_cnt != '0;
   assign full     = cred_cnt == CRED_W'(MAX_CRED);
   // a return into a full pool only counts when this cycle also takes a credit
   assign give     = cred_ret && !(full && !grant);
   assign req_yumi = grant ? gnt : '0;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         snd_valid <= 1'b0;
         snd_data  <= '0;
         snd_dest  <= '0;
         ptr       <= '0;
         cred_cnt  <= CRED_W'(MAX_CRED);
         cred_err  <= 1'b0;
      end else begin
         if (grant) begin
            state     <= SEND;
            snd_valid <= 1'b1;
            snd_data  <= req_data[idx*DATA_W +: DATA_W];
            snd_dest  <= req_dest[idx*DEST_W +: DEST_W];
            ptr       <= (idx == IDX_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
         end else if (state == SEND && snd_ready) begin
            state     <= IDLE;
            snd_valid <= 1'b0;
         end
         cred_cnt <= cred_cnt - CRED_W'(grant) + CRED_W'(give);
         cred_err <= cred_err | (cred_ret && full && !grant);
      end
   end
`ifdef MPI_TX_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_count     <= '0;
         stall_cycles <= '0;
      end else begin
         if (snd_valid && snd_ready) tx_count <= tx_count + 32'd1;
         if (state == IDLE && |req_valid && cred_cnt == '0 && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mpi_tx_sched.sv
// tb_mpi_tx_sched: vector table plus cycle model and message scoreboard for mpi_tx_sched.
module tb_mpi_tx_sched;
   import mpi_pkg::*;
   localparam int N = 4;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*64-1:0] req_data;
   logic [N*32-1:0] req_dest;
   logic [N-1:0]    req_yumi;
   logic            snd_valid;
   logic [63:0]     snd_data;
   logic [31:0]     snd_dest;
   logic            snd_ready = 1'b0, cred_ret = 1'b0;
   logic [2:0]      cred_cnt;
   logic            cred_err;
`ifdef MPI_TX_SCHED_STATS_EN
   logic [31:0]     tx_count, stall_cycles;
`endif
   int errors = 0, checks = 0;
   mpi_msg_t lane [N];
   mpi_msg_t sb [$];
   logic m_send, m_err;
   int   m_ptr, m_cred;
   logic [N-1:0] last_yumi;
   logic last_sv, last_err, last_acc;
   logic [2:0] last_cred;
   typedef struct {
      logic [3:0] v;
      logic       rdy, ret;
      logic [3:0] yumi;
      logic       sv;
      logic [2:0] cred;
      logic       err;
   } vec_t;
   vec_t tbl [14];

   mpi_tx_sched dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_dest(req_dest),
      .req_yumi(req_yumi), .snd_valid(snd_valid), .snd_data(snd_data), .snd_dest(snd_dest),
      .snd_ready(snd_ready), .cred_ret(cred_ret), .cred_cnt(cred_cnt), .cred_err(cred_err)
`ifdef MPI_TX_SCHED_STATS_EN
      , .tx_count(tx_count), .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_send = 1'b0; m_err = 1'b0; m_ptr = 0; m_cred = 4;
      sb.delete();
   endtask

   // one clock: compare against the model at negedge, advance the model, return just after posedge
   task automatic cycle();
      logic [N-1:0] my;
      int w;
      mpi_msg_t exp;
      @(negedge clk);
      my = '0;
      w  = -1;
      if (!m_send && req_valid != '0 && m_cred != 0)
         for (int i = 0; i < N; i++)
            if (w < 0 && req_valid[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      if (w >= 0) my[w] = 1'b1;
      last_yumi = req_yumi; last_sv = snd_valid; last_cred = cred_cnt; last_err = cred_err;
      chk("yumi", 64'(req_yumi), 64'(my));
      chk("snd_valid", 64'(snd_valid), 64'(m_send));
      chk("cred_cnt", 64'(cred_cnt), 64'(m_cred));
      chk("cred_err", 64'(cred_err), 64'(m_err));
      if (rst_n && snd_valid && snd_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow: got accept expected none at %0t", $time);
         end else begin
            exp = sb.pop_front();
            chk("snd_data", snd_data, exp.data);
            chk("snd_dest", 64'(snd_dest), 64'(exp.dest));
         end
      end
      if (!rst_n) model_reset();
      else begin
         if (w >= 0) begin
            m_send = 1'b1;
            m_ptr  = (w + 1) % N;
            sb.push_back(lane[w]);
         end else if (m_send && snd_ready) m_send = 1'b0;
         if (w >= 0 && !cred_ret) m_cred--;
         else if (w < 0 && cred_ret) begin
            if (m_cred == 4) m_err = 1'b1;
            else m_cred++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0; snd_ready = 1'b0; cred_ret = 1'b0;
      cycle();
      rst_n = 1'b1;
      last_acc = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int wins [$];
      int at [$];
      for (int i = 0; i < N; i++) begin
         lane[i].data = 64'hA5 + 64'(i) * 64'h1111_0000;
         lane[i].dest = 32'(i * 3);
         req_data[i*64 +: 64] = lane[i].data;
         req_dest[i*32 +: 32] = lane[i].dest;
      end
      tbl[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 3'd4, 1'b0};
      tbl[1]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd3, 1'b0};
      tbl[2]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 3'd3, 1'b0};
      tbl[3]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 3'd4, 1'b0};
      tbl[4]  = '{4'b0110, 1'b0, 1'b0, 4'b0010, 1'b0, 3'd4, 1'b1};
      tbl[5]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd3, 1'b1};
      tbl[6]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd3, 1'b1};
      tbl[7]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd3, 1'b1};
      tbl[8]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 3'd3, 1'b1};
      tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd3, 1'b1};
      tbl[10] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b0, 3'd3, 1'b1};
      tbl[11] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd2, 1'b1};
      tbl[12] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 3'd2, 1'b1};
      tbl[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd1, 1'b1};
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      last_acc = 1'b0;
      chk("rst_snd_valid", 64'(snd_valid), 64'd0);
      chk("rst_snd_data", snd_data, 64'd0);
      chk("rst_snd_dest", 64'(snd_dest), 64'd0);
      chk("rst_cred_cnt", 64'(cred_cnt), 64'd4);
      chk("rst_cred_err", 64'(cred_err), 64'd0);
      for (int i = 0; i < 14; i++) begin
         req_valid = tbl[i].v; snd_ready = tbl[i].rdy; cred_ret = tbl[i].ret;
         cycle();
         chk("tbl_yumi", 64'(last_yumi), 64'(tbl[i].yumi));
         chk("tbl_snd_valid", 64'(last_sv), 64'(tbl[i].sv));
         chk("tbl_cred_cnt", 64'(last_cred), 64'(tbl[i].cred));
         chk("tbl_cred_err", 64'(last_err), 64'(tbl[i].err));
      end
      // round robin with credits returned the cycle after each accept
      do_reset();
      req_valid = '1; snd_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cred_ret = last_acc;
         cycle();
         last_acc = last_sv && snd_ready;
         if (last_yumi != '0) begin
            wins.push_back($clog2(last_yumi));
            at.push_back(c);
         end
      end
      cred_ret = 1'b0;
      chk("rr_count", 64'(wins.size()), 64'd5);
      for (int k = 0; k < wins.size() && k < 5; k++) begin
         chk("rr_order", 64'(wins[k]), 64'(k % 4));
         if (k > 0) chk("rr_gap", 64'(at[k] - at[k-1]), 64'd2);
      end
      // credit exhaustion, then a single return
      do_reset();
      req_valid = '1; snd_ready = 1'b1; cnt = 0;
      for (int c = 0; c < 12; c++) begin
         cycle();
         if (last_yumi != '0) cnt++;
      end
      chk("cred_grants", 64'(cnt), 64'd4);
      chk("cred_zero", 64'(cred_cnt), 64'd0);
      cred_ret = 1'b1;
      cycle();
      chk("no_grant_at_zero", 64'(last_yumi), 64'd0);
      cred_ret = 1'b0;
      cycle();
      chk("grant_after_ret", 64'(last_yumi), 64'b0001);
      // backpressure in SEND
      do_reset();
      req_valid = 4'b0010; snd_ready = 1'b0;
      cycle();
      req_valid = '1;
      for (int c = 0; c < 5; c++) begin
         cycle();
         chk("stall_yumi", 64'(last_yumi), 64'd0);
         chk("stall_valid", 64'(snd_valid), 64'd1);
         chk("stall_data", snd_data, lane[1].data);
         chk("stall_dest", 64'(snd_dest), 64'(lane[1].dest));
      end
      snd_ready = 1'b1;
      cycle();
      snd_ready = 1'b0;
      cycle();
      chk("ptr_hold", 64'(last_yumi), 64'b0100);
      // take and return in the same cycle
      do_reset();
      req_valid = '1; snd_ready = 1'b1;
      repeat (4) cycle();
      cred_ret = 1'b1;
      cycle();
      cred_ret = 1'b0;
      chk("take_give_grant", 64'(last_yumi), 64'b0100);
      chk("take_give_cred", 64'(cred_cnt), 64'd2);
      // reset while holding a message
      do_reset();
      cred_ret = 1'b1;
      cycle();
      cred_ret = 1'b0; req_valid = 4'b0001; snd_ready = 1'b0;
      cycle();
      req_valid = '0;
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      chk("rst_send_valid", 64'(snd_valid), 64'd0);
      chk("rst_send_cred", 64'(cred_cnt), 64'd4);
      chk("rst_send_err", 64'(cred_err), 64'd0);
      chk("rst_send_data", snd_data, 64'd0);
      req_valid = 4'b1000;
      cycle();
      chk("rst_send_idle_grant", 64'(last_yumi), 64'b1000);
      req_valid = '0;
      cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
